// File: rtl/rf_pkg.sv
// Shared defaults and types for the bypassing register file and its scoreboard.
package rf_pkg;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = $clog2(NREG);

    typedef logic [AW-1:0]   reg_idx_t;
    typedef logic [XLEN-1:0] xword_t;

    // x0 is hardwired to zero and never tracked by the scoreboard
    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/rf_bypass_scoreboard_if.sv
// Decode/writeback-facing bundle of the register file: read ports, write port,
// issue tracking and hazard outputs.
interface rf_bypass_scoreboard_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
);
    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [NRD-1:0]      ren;
    logic [NRD*AW-1:0]   ra;
    logic [NRD*XLEN-1:0] rd;
    logic                we;
    logic [AW-1:0]       wa;
    logic [XLEN-1:0]     wd;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                flush;
    logic                stall;
    logic [CW-1:0]       busy_count;

    // Pipeline side (decode + writeback) drives requests
    modport master (
        output ren, ra, we, wa, wd, issue_valid, issue_rd, flush,
        input  rd, stall, busy_count
    );

    // Register file side
    modport slave (
        input  ren, ra, we, wa, wd, issue_valid, issue_rd, flush,
        output rd, stall, busy_count
    );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, RAW/WAW stall detection
// and a registered population count of outstanding writes.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREG = rf_pkg::NREG,
    parameter int NRD  = 2,
    parameter int AW   = $clog2(NREG),
    parameter int CW   = $clog2(NREG + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD-1:0]    i_ren,
    input  logic [NRD*AW-1:0] i_ra,
    input  logic              i_we,
    input  logic [AW-1:0]     i_wa,
    input  logic              i_issue_valid,
    input  logic [AW-1:0]     i_issue_rd,
    input  logic              i_flush,
    output logic              o_stall,
    output logic [CW-1:0]     o_busy_count
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_nxt;
    logic [NRD-1:0]  w_raw;
    logic            w_waw;
    logic [CW-1:0]   w_cnt_nxt;

    // A writeback landing this cycle resolves the hazard through the bypass
    for (genvar g = 0; g < NRD; g++) begin : g_raw
        logic [AW-1:0] w_ra;
        assign w_ra     = i_ra[g*AW +: AW];
        assign w_raw[g] = i_ren[g] && (w_ra != AW'(ZERO_REG)) && r_busy[w_ra]
                          && !(i_we && (i_wa == w_ra));
    end

    assign w_waw = i_issue_valid && (i_issue_rd != AW'(ZERO_REG)) && r_busy[i_issue_rd]
                   && !(i_we && (i_wa == i_issue_rd));

    assign o_stall = (|w_raw) || w_waw;

    // Next busy vector: flush dominates, then writeback clear, then issue set
    always_comb begin
        w_busy_nxt = r_busy;
        if (i_flush) begin
            w_busy_nxt = '0;
        end else begin
            if (i_we) begin
                w_busy_nxt[i_wa] = 1'b0;
            end
            if (i_issue_valid && (i_issue_rd != AW'(ZERO_REG)) && !o_stall) begin
                w_busy_nxt[i_issue_rd] = 1'b1;
            end
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Population count of the next busy vector
    always_comb begin
        w_cnt_nxt = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            w_cnt_nxt = w_cnt_nxt + CW'(w_busy_nxt[i]);
        end
    end

    // Busy bits and their count update together
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy       <= '0;
            o_busy_count <= '0;
        end else begin
            r_busy       <= w_busy_nxt;
            o_busy_count <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/rf_bypass_scoreboard.sv
// Multi-read-port integer register file with write-first bypass, asynchronous
// clear and a pending-write scoreboard for the 5-stage RV32I pipeline.
module rf_bypass_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN = rf_pkg::XLEN,
    parameter int NREG = rf_pkg::NREG,
    parameter int NRD  = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    rf_bypass_scoreboard_if.slave  bus
);

    localparam int AW = $clog2(NREG);
    localparam int CW = $clog2(NREG + 1);

    logic [XLEN-1:0] r_mem [NREG];

    // Array write; x0 is never stored so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (bus.we && (bus.wa != AW'(ZERO_REG))) begin
            r_mem[bus.wa] <= bus.wd;
        end
    end

    // Combinational read per port; reset forces zero so a bypassed wd cannot leak
    for (genvar g = 0; g < NRD; g++) begin : g_rd
        logic [AW-1:0]   w_ra;
        logic [XLEN-1:0] w_rd;
        assign w_ra = bus.ra[g*AW +: AW];

        // x0, then same-cycle writeback, then stored value
        always_comb begin
            w_rd = r_mem[w_ra];
            if (!rst_n || (w_ra == AW'(ZERO_REG))) begin
                w_rd = '0;
            end else if (bus.we && (bus.wa == w_ra)) begin
                w_rd = bus.wd;
            end
        end

        assign bus.rd[g*XLEN +: XLEN] = w_rd;
    end

    rf_scoreboard #(
        .NREG (NREG),
        .NRD  (NRD),
        .AW   (AW),
        .CW   (CW)
    ) u_sb (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_ren         (bus.ren),
        .i_ra          (bus.ra),
        .i_we          (bus.we),
        .i_wa          (bus.wa),
        .i_issue_valid (bus.issue_valid),
        .i_issue_rd    (bus.issue_rd),
        .i_flush       (bus.flush),
        .o_stall       (bus.stall),
        .o_busy_count  (bus.busy_count)
    );

endmodule

// File: tb/tb_rf_bypass_scoreboard.sv
// Directed bench for rf_bypass_scoreboard: bypass, x0, RAW/WAW stalls, flush
// and asynchronous reset, all against hand-computed values.
module tb_rf_bypass_scoreboard;
    import rf_pkg::*;

    logic clk;
    logic rst_n;
    int   n_tot;
    int   n_bad;

    rf_bypass_scoreboard_if #(.XLEN(32), .NREG(32), .NRD(2)) bus ();

    rf_bypass_scoreboard #(.XLEN(32), .NREG(32), .NRD(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tot++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp_v);
        end
    endtask

    // Advance past the next rising edge; inputs then change away from it
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rd0();
        return bus.rd[31:0];
    endfunction

    function automatic logic [31:0] rd1();
        return bus.rd[63:32];
    endfunction

    task automatic set_ra(input reg_idx_t a0, input reg_idx_t a1);
        bus.ra = {a1, a0};
    endtask

    initial begin
        n_tot = 0;
        n_bad = 0;
        rst_n = 1'b0;
        bus.ren = '0;
        bus.ra = '0;
        bus.we = 1'b0;
        bus.wa = '0;
        bus.wd = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd = '0;
        bus.flush = 1'b0;

        // During reset, even a bypass candidate reads zero
        set_ra(5'd5, 5'd5);
        bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'h1111_2222;
        #12;
        chk("rst_rd0", rd0(), 32'h0);
        chk("rst_rd1", rd1(), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);
        chk("rst_cnt", 32'(bus.busy_count), 32'h0);
        bus.we = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post_rst_rd0", rd0(), 32'h0);
        chk("post_rst_rd1", rd1(), 32'h0);

        // Write to x0 is dropped
        cyc();
        bus.we = 1'b1; bus.wa = ZERO_REG; bus.wd = 32'hDEAD_BEEF;
        set_ra(ZERO_REG, ZERO_REG);
        #1;
        chk("x0_bypass", rd0(), 32'h0);
        cyc();
        bus.we = 1'b0;
        #1;
        chk("x0_read", rd0(), 32'h0);
        chk("x0_cnt", 32'(bus.busy_count), 32'h0);

        // Same-cycle bypass on both ports, then array read
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h1234_5678;
        set_ra(5'd7, 5'd7);
        #1;
        chk("byp_rd0", rd0(), 32'h1234_5678);
        chk("byp_rd1", rd1(), 32'h1234_5678);
        cyc();
        bus.we = 1'b0;
        #1;
        chk("arr_rd0", rd0(), 32'h1234_5678);
        chk("arr_rd1", rd1(), 32'h1234_5678);
        chk("nonbusy_wr_cnt", 32'(bus.busy_count), 32'h0);

        // RAW hazard on x3
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
        #1;
        chk("raw_issue_stall", 32'(bus.stall), 32'h0);
        cyc();
        bus.issue_valid = 1'b0;
        bus.ren = 2'b01; set_ra(5'd3, 5'd0);
        #1;
        chk("raw_cnt1", 32'(bus.busy_count), 32'h1);
        chk("raw_stall", 32'(bus.stall), 32'h1);
        cyc();
        chk("raw_stall_hold", 32'(bus.stall), 32'h1);
        bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h0000_00A5;
        #1;
        chk("raw_wb_stall", 32'(bus.stall), 32'h0);
        chk("raw_wb_rd0", rd0(), 32'h0000_00A5);
        cyc();
        bus.we = 1'b0;
        #1;
        chk("raw_cnt0", 32'(bus.busy_count), 32'h0);
        chk("raw_after_stall", 32'(bus.stall), 32'h0);
        chk("raw_after_rd0", rd0(), 32'h0000_00A5);

        // WAW hazard on x4
        bus.ren = 2'b00;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        cyc();
        #1;
        chk("waw_cnt1", 32'(bus.busy_count), 32'h1);
        chk("waw_stall", 32'(bus.stall), 32'h1);
        cyc();
        chk("waw_cnt_hold", 32'(bus.busy_count), 32'h1);
        bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h0000_0044;
        #1;
        chk("waw_wb_stall", 32'(bus.stall), 32'h0);
        cyc();
        bus.we = 1'b0; bus.issue_valid = 1'b0;
        bus.ren = 2'b01; set_ra(5'd4, 5'd0);
        #1;
        chk("waw_set_wins_cnt", 32'(bus.busy_count), 32'h1);
        chk("waw_set_wins_stall", 32'(bus.stall), 32'h1);
        // RAW seen on port 1 alone
        bus.ren = 2'b10; set_ra(5'd0, 5'd4);
        #1;
        chk("raw_port1_stall", 32'(bus.stall), 32'h1);
        // Port 1 address busy but its enable is low
        bus.ren = 2'b01;
        #1;
        chk("raw_ren_off_stall", 32'(bus.stall), 32'h0);
        bus.ren = 2'b00;
        // Issue to x0 is never tracked
        bus.issue_valid = 1'b1; bus.issue_rd = ZERO_REG;
        #1;
        chk("x0_issue_stall", 32'(bus.stall), 32'h0);
        cyc();
        bus.issue_valid = 1'b0;
        #1;
        chk("x0_issue_cnt", 32'(bus.busy_count), 32'h1);

        // Retire x4, then flush three pending writes
        bus.we = 1'b1; bus.wa = 5'd4; bus.wd = 32'h0000_0044;
        cyc();
        bus.we = 1'b0;
        #1;
        chk("x4_retire_cnt", 32'(bus.busy_count), 32'h0);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd1;
        cyc();
        bus.issue_rd = 5'd2;
        cyc();
        bus.issue_rd = 5'd9;
        cyc();
        #1;
        chk("fl_cnt3", 32'(bus.busy_count), 32'h3);
        // Flush ignores this issue, but the array write still lands
        bus.issue_rd = 5'd5;
        bus.flush = 1'b1;
        bus.we = 1'b1; bus.wa = 5'd20; bus.wd = 32'h0000_0077;
        cyc();
        bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.we = 1'b0;
        bus.ren = 2'b01; set_ra(5'd9, 5'd20);
        #1;
        chk("fl_cnt0", 32'(bus.busy_count), 32'h0);
        chk("fl_stall", 32'(bus.stall), 32'h0);
        chk("fl_write_rd1", rd1(), 32'h0000_0077);

        // Async reset mid-operation: x7=0x55, x10 and x11 pending
        bus.ren = 2'b00;
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h0000_0055;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd10;
        cyc();
        bus.we = 1'b0;
        bus.issue_rd = 5'd11;
        cyc();
        bus.issue_valid = 1'b0;
        bus.ren = 2'b11; set_ra(5'd7, 5'd10);
        #1;
        chk("pre_rst_cnt", 32'(bus.busy_count), 32'h2);
        chk("pre_rst_rd0", rd0(), 32'h0000_0055);
        chk("pre_rst_stall", 32'(bus.stall), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("arst_rd0", rd0(), 32'h0);
        chk("arst_rd1", rd1(), 32'h0);
        chk("arst_cnt", 32'(bus.busy_count), 32'h0);
        chk("arst_stall", 32'(bus.stall), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("arst_rel_rd0", rd0(), 32'h0);
        chk("arst_rel_stall", 32'(bus.stall), 32'h0);
        // First edge after release is a normal cycle
        bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'h0000_0099;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
        cyc();
        bus.we = 1'b0; bus.issue_valid = 1'b0;
        #1;
        chk("post_arst_rd0", rd0(), 32'h0000_0099);
        chk("post_arst_cnt", 32'(bus.busy_count), 32'h1);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
